// File: rtl/kernel_bc_pkg.sv
// kernel_bc_pkg
// Shared constants and helpers for the kernel_bc start-token reader.
//   OUTST_W              width of the outstanding-invocation counter
//   DEF_MAX_OUTSTANDING  default overlap limit (pending start included)
//   DEF_CNT_WIDTH        default statistics counter width
//   DEF_DATA_WIDTH       default start-token payload width
//   inflight_of()        outstanding invocations plus the pending start
package kernel_bc_pkg;

    localparam int OUTST_W             = 4;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_CNT_WIDTH       = 16;
    localparam int DEF_DATA_WIDTH      = 1;

    // One bit wider than the counter so outst + pend can never wrap.
    function automatic logic [OUTST_W:0] inflight_of(
        input logic [OUTST_W-1:0] outst,
        input logic               pend
    );
        return {1'b0, outst} + {{OUTST_W{1'b0}}, pend};
    endfunction

endpackage

// File: rtl/kernel_bc_token_counter.sv
// kernel_bc_token_counter
// Up/down occupancy counter that never wraps in either direction.
//   clk, rst_n  clock and synchronous active-low reset
//   inc, dec    count up / count down; both together leave the count alone
//   count       current occupancy
//   at_limit    count has reached LIMIT
//   is_zero     count is zero
module kernel_bc_token_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             at_limit,
    output logic             is_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturate at both ends instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != '1)) begin
            count_d = count_q + ONE;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q >= LIM);
    assign is_zero  = (count_q == '0);

endmodule

// File: rtl/kernel_bc_start_token_reader.sv
// kernel_bc_start_token_reader
// Consumer end of a start-propagation FIFO: pops start tokens, drives the
// ap_ctrl handshake of one dataflow process with up to MAX_OUTSTANDING
// overlapped invocations, and forwards each completion as a done token.
//   ap_clk, ap_rst_n            clock, synchronous active-low reset
//   enable                      allow new pops
//   start_empty_n/dout/read     upstream FIFO read port
//   ap_start/ap_start_data      start request and its payload
//   ap_ready, ap_done           process handshake inputs
//   ap_continue                 done acknowledge (follows done_full_n)
//   done_full_n, done_write     downstream FIFO write port
//   idle                        nothing pending and nothing outstanding
//   start_cnt, done_cnt         issued / forwarded statistics (wrapping)
//   err_underflow               sticky: ap_done with nothing outstanding
module kernel_bc_start_token_reader
    import kernel_bc_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  enable,
    input  logic                  start_empty_n,
    input  logic [DATA_WIDTH-1:0] start_dout,
    output logic                  start_read,
    output logic                  ap_start,
    output logic [DATA_WIDTH-1:0] ap_start_data,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic                  ap_continue,
    input  logic                  done_full_n,
    output logic                  done_write,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  start_cnt,
    output logic [CNT_WIDTH-1:0]  done_cnt,
    output logic                  err_underflow
);

    localparam logic [OUTST_W:0] MAX_INFLIGHT = MAX_OUTSTANDING[OUTST_W:0];

    logic                  pend_q,      pend_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic [CNT_WIDTH-1:0]  start_cnt_q, start_cnt_d;
    logic [CNT_WIDTH-1:0]  done_cnt_q,  done_cnt_d;
    logic                  err_q,       err_d;

    logic [OUTST_W-1:0]    outst;
    logic                  outst_at_limit;
    logic                  outst_zero;
    logic [OUTST_W:0]      inflight;
    logic                  room;
    logic                  pop;
    logic                  start_fire;
    logic                  done_ok;
    logic                  done_fire;
    logic                  underflow;

    kernel_bc_token_counter #(
        .WIDTH (OUTST_W),
        .LIMIT (MAX_OUTSTANDING)
    ) u_outst (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .inc      (start_fire),
        .dec      (done_fire),
        .count    (outst),
        .at_limit (outst_at_limit),
        .is_zero  (outst_zero)
    );

    // Room is judged on registered state only, so a done in the same cycle
    // never opens a slot early. The pending start counts against the limit.
    always_comb begin
        inflight   = inflight_of(outst, pend_q);
        room       = !outst_at_limit && (inflight < MAX_INFLIGHT);
        pop        = ap_rst_n && enable && start_empty_n
                     && (!pend_q || ap_ready) && room;
        start_fire = pend_q && ap_ready;
        done_ok    = ap_done && done_full_n;
        done_fire  = ap_rst_n && done_ok && !outst_zero;
        underflow  = done_ok && outst_zero;
    end

    // A pop in the same cycle as ap_ready refills pend, giving one issue per cycle.
    always_comb begin
        pend_d      = pend_q;
        data_d      = data_q;
        start_cnt_d = start_cnt_q + CNT_WIDTH'(start_fire);
        done_cnt_d  = done_cnt_q + CNT_WIDTH'(done_fire);
        err_d       = err_q | underflow;
        if (pop) begin
            pend_d = 1'b1;
            data_d = start_dout;
        end else if (start_fire) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            pend_q      <= 1'b0;
            data_q      <= '0;
            start_cnt_q <= '0;
            done_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            data_q      <= data_d;
            start_cnt_q <= start_cnt_d;
            done_cnt_q  <= done_cnt_d;
            err_q       <= err_d;
        end
    end

    assign start_read    = pop;
    assign ap_start      = pend_q;
    assign ap_start_data = data_q;
    assign ap_continue   = ap_rst_n && done_full_n;
    assign done_write    = done_fire;
    assign idle          = !pend_q && outst_zero;
    assign start_cnt     = start_cnt_q;
    assign done_cnt      = done_cnt_q;
    assign err_underflow = err_q;

endmodule

// File: doc/kernel_bc_start_token_reader.md
Name: kernel_bc_start_token_reader

Overview:
- Consumer-side end of a dataflow start-propagation FIFO in kernel_bc. Pops start tokens from an upstream start_for_* FIFO and drives the ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue) of one downstream dataflow process.
- Allows up to MAX_OUTSTANDING overlapped invocations.
- Forwards each completion as a done token to the next FIFO's write port.

Parameters:
- DATA_WIDTH, 1: width of the start-token payload.
- MAX_OUTSTANDING, 4: maximum accepted-but-not-done invocations, counting the pending start. Range 1..15.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = new tokens may be popped.
- start_empty_n  in  1  upstream FIFO holds a token.
- start_dout  in  DATA_WIDTH  upstream FIFO head payload.
- start_read  out  1  pop strobe to the upstream FIFO.
- ap_start  out  1  start request to the process.
- ap_start_data  out  DATA_WIDTH  payload of the token currently pending or last issued.
- ap_ready  in  1  process accepted the start.
- ap_done  in  1  process finished one invocation.
- ap_continue  out  1  done acknowledge to the process.
- done_full_n  in  1  downstream FIFO has room.
- done_write  out  1  write strobe to the downstream FIFO; payload is fixed 1'b1 outside this block.
- idle  out  1  no pending start and no outstanding invocation.
- start_cnt  out  CNT_WIDTH  tokens issued (ap_ready handshakes).
- done_cnt  out  CNT_WIDTH  completions forwarded.
- err_underflow  out  1  sticky: ap_done seen while nothing was outstanding.

Behaviour:
- State:
  - pend (1 bit): a token has been popped, ap_ready not yet seen.
  - outst (4 bits): invocations started, not yet done.
  - inflight = outst + pend.
- Reset (ap_rst_n == 0 at the clock edge): pend=0, outst=0, ap_start_data=0, start_cnt=0, done_cnt=0, err_underflow=0.
  - While ap_rst_n == 0, the combinational outputs start_read, done_write and ap_continue are forced to 0.
  - A token held in pend at reset is discarded, not re-issued.
- ap_start = pend, driven from a register.
- Pop rule: start_read = enable & start_empty_n & (~pend | ap_ready) & (inflight < MAX_OUTSTANDING).
  - A same-cycle ap_done does not create room.
  - On a pop, pend <= 1 and ap_start_data <= start_dout.
  - Pop-to-ap_start latency is 1 cycle.
  - If ap_ready and a pop happen in the same cycle, pend stays 1 and back-to-back issue is one token per cycle.
- Start handshake: if pend & ap_ready, start_cnt increments, and outst increments unless the done event below also fires.
  - ap_ready while pend == 0 is ignored.
- Done handshake:
  - ap_continue = done_full_n.
  - Done event = ap_done & done_full_n & (outst != 0). On a done event: done_write = 1, outst decrements, done_cnt increments.
  - A start and a done in the same cycle leave outst unchanged and increment both counters.
  - ap_done & done_full_n with outst == 0: err_underflow <= 1, no write, no counter change.
  - ap_done while done_full_n == 0: ap_continue is held low; the process holds ap_done.
- idle = ~pend & (outst == 0), combinational from registers.
- Counters wrap modulo 2^CNT_WIDTH.
- Deasserting enable blocks further pops only. A pending token is still issued and outstanding invocations still drain.
- Invariant: inflight never exceeds MAX_OUTSTANDING; with MAX_OUTSTANDING=1 the block is fully serial.

Decomposition:
- Shared package kernel_bc_pkg holds:
  - constant OUTST_W = 4;
  - localparams for the default MAX_OUTSTANDING and CNT_WIDTH.
- One natural sub-module, kernel_bc_token_counter: a generic saturating-range up/down occupancy counter with inc, dec and at-limit flag, used for outst.
- Statistics counters are inline.

Test Plan:
- Reset and single token: after reset, one token with start_dout=1; ap_ready on the cycle after ap_start; ap_done 3 cycles later with done_full_n=1. Required: start_read pulses once; ap_start high for 1 cycle with ap_start_data=1; done_write pulses once; final start_cnt=1, done_cnt=1, idle=1.
- Back-to-back tokens: 6 tokens, MAX_OUTSTANDING=4, ap_ready held 1, no ap_done. Required: exactly 4 pops on consecutive cycles; start_read then stays 0 with inflight=4. Then 2 ap_done pulses → 2 more pops; start_cnt=6.
- Downstream backpressure: done_full_n=0 while ap_done is held for 5 cycles. Required: ap_continue=0 and done_write=0 for those 5 cycles. On done_full_n=1, exactly one done_write; outst decrements by 1.
- Simultaneous start and done: outst=2, pend=1, with ap_ready and ap_done in the same cycle. Required: outst stays 2; start_cnt and done_cnt each increment by 1; a pop is allowed that cycle if a token is available.
- Underflow and enable: ap_done with idle=1 → err_underflow=1, done_cnt unchanged. Then enable=0 with 3 tokens present → no start_read; pending work still completes.
- Reset mid-operation: ap_rst_n=0 for 1 cycle with pend=1 and outst=2. Required: all registers are zero on the next cycle, ap_start=0, no spurious done_write; a later token restarts cleanly.
